// File: rtl/boot_pkg.sv
// Shared boot-loader types and defaults.
// Used by the UART instruction-memory loader, its wrapper and the bench.
package boot_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [31:0] DEF_END_WORD = 32'hFFFF_FFFF;
  // 40 ms of line silence at 50 MHz
  localparam int unsigned DEF_TIMEOUT_CYC = 2_000_000;

  function automatic logic [31:0] put_lane(
    input logic [31:0] w,
    input logic [1:0]  idx,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = w;
    r[8*idx +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/uart_imem_loader_if.sv
// Byte stream in from the UART receiver, word writes out to the
// instruction memory.
interface uart_imem_loader_if #(
  parameter int ADDR_W = 8
);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_break;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_valid,
    input  rx_data,
    input  rx_break,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_valid,
    output rx_data,
    output rx_break,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/loader_timeout.sv
// Loadable down-counter that flags a stalled partial word.
// load wins over clear; expire pulses when the count runs out.
module loader_timeout
  import boot_pkg::*;
#(
  parameter int unsigned CNT_MAX = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CNT_MAX - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = ~load & ~clear & (cnt == '0);

endmodule

// File: rtl/uart_imem_loader.sv
// Packs UART bytes into instruction words and writes them to imem,
// holding the core in reset until the terminator word arrives.
module uart_imem_loader
  import boot_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] END_WORD    = DEF_END_WORD,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                resetn,
  uart_imem_loader_if.master  bus,
  output logic                write_done,
  output logic                core_resetn,
  output logic [ADDR_W:0]     word_count,
  output logic                overflow,
  output logic                resync_err
);

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       buf_q, buf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              crst_q, crst_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              rerr_q, rerr_d;

  logic        in_load;
  logic        brk;
  logic        acc;
  logic        tmo;
  logic        expire;
  logic        tmr_clear;
  logic        full;
  logic [31:0] word;

  assign in_load = (state_q == LOAD);
  assign brk     = in_load & bus.rx_break;
  assign acc     = in_load & bus.rx_valid & ~bus.rx_break;
  assign tmo     = in_load & expire & ~bus.rx_break;
  assign full    = cnt_q[ADDR_W];
  assign word    = {bus.rx_data, buf_q[23:0]};

  // Idle timer only runs while a word is partially assembled
  assign tmr_clear = ~in_load | (idx_q == 2'd0) | bus.rx_break;

  loader_timeout #(
    .CNT_MAX(TIMEOUT_CYC)
  ) u_tmr (
    .clk    (clk),
    .resetn (resetn),
    .load   (acc),
    .clear  (tmr_clear),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= LOAD;
      idx_q   <= '0;
      buf_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      crst_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      crst_q  <= crst_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rerr_q  <= rerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    rerr_d  = rerr_q;
    unique case (1'b1)
      brk: begin
        idx_d = '0;
        if (idx_q != 2'd0) rerr_d = 1'b1;
      end
      acc: begin
        buf_d = put_lane(buf_q, idx_q, bus.rx_data);
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          if (word == END_WORD) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (!full) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = word;
            cnt_d   = cnt_q + (ADDR_W+1)'(1);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            ovf_d   = 1'b1;
          end
        end
      end
      tmo: begin
        idx_d  = '0;
        rerr_d = 1'b1;
      end
      default: ;
    endcase
    crst_d = done_d & ~ovf_d;
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign write_done     = done_q;
  assign core_resetn    = crst_q;
  assign word_count     = cnt_q;
  assign overflow       = ovf_q;
  assign resync_err     = rerr_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Randomized bench for uart_imem_loader with a byte-stream
// reference model and a write monitor.
module tb_uart_imem_loader;
  import boot_pkg::*;

  localparam int AW    = 4;
  localparam int TO    = 100;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic write_done, core_resetn, overflow, resync_err;
  logic [AW:0] word_count;

  always #10 clk = ~clk;

  uart_imem_loader_if #(.ADDR_W(AW)) bus ();

  uart_imem_loader #(
    .ADDR_W      (AW),
    .END_WORD    (DEF_END_WORD),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .write_done  (write_done),
    .core_resetn (core_resetn),
    .word_count  (word_count),
    .overflow    (overflow),
    .resync_err  (resync_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+31:0] got_q[$];
  logic [AW+31:0] exp_q[$];

  logic [7:0] m_bytes[$];
  int m_count;
  bit m_done, m_ovf, m_resync;

  always @(negedge clk)
    if (bus.imem_we === 1'b1)
      got_q.push_back({bus.imem_addr, bus.imem_wdata});

  function automatic void model_reset();
    m_bytes.delete();
    exp_q.delete();
    m_count  = 0;
    m_done   = 0;
    m_ovf    = 0;
    m_resync = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [31:0] w;
    logic [AW-1:0] a;
    if (m_done) return;
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      m_bytes.delete();
      if (w == DEF_END_WORD) begin
        m_done = 1;
      end else if (m_count < DEPTH) begin
        a = m_count[AW-1:0];
        exp_q.push_back({a, w});
        m_count++;
      end else begin
        m_ovf  = 1;
        m_done = 1;
      end
    end
  endfunction

  function automatic void model_drop();
    if (m_done) return;
    if (m_bytes.size() != 0) m_resync = 1;
    m_bytes.delete();
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    model_byte(b);
    cyc(1);
    bus.rx_valid = 1'b0;
    bus.rx_data  = $urandom;
    cyc(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom; while (w == DEF_END_WORD);
    return w;
  endfunction

  task automatic do_reset();
    resetn       = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_break = 1'b0;
    bus.rx_data  = '0;
    #4000;
    got_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got %b/%h/%h expected 0/0/0",
               bus.imem_we, bus.imem_addr, bus.imem_wdata);
    end
    n_checks++;
    if ({write_done, core_resetn, overflow, resync_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b%b%b%b expected 0000",
               write_done, core_resetn, overflow, resync_err);
    end
    n_checks++;
    if (word_count !== '0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", word_count);
    end
  endtask

  task automatic test_basic();
    do_reset();
    send_word(32'h0000_0000, 1);
    send_word(32'hFD01_0113, 0);
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hFF;
    model_byte(8'hFF);
    @(negedge clk);
    n_checks++;
    if (write_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_done: got %b expected 0", write_done);
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    n_checks++;
    if ({write_done, core_resetn} !== 2'b11) begin
      n_fail++;
      $display("FAIL basic_done: got %b%b expected 11",
               write_done, core_resetn);
    end
    n_checks++;
    if (word_count !== 5'd2) begin
      n_fail++;
      $display("FAIL basic_count: got %0d expected 2", word_count);
    end
    cyc(2);
    n_checks++;
    if (got_q.size() != 2 || got_q[0] !== {4'd0, 32'h0000_0000} ||
        got_q[1] !== {4'd1, 32'hFD01_0113}) begin
      n_fail++;
      $display("FAIL basic_writes: got %p expected %p", got_q, exp_q);
    end
  endtask

  task automatic test_double_term();
    send_word(32'hFFFF_FFFF, 0);
    send_word(rand_word(), 1);
    cyc(3);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL dterm_writes: got %0d expected %0d",
               got_q.size(), exp_q.size());
    end
    n_checks++;
    if ({write_done, core_resetn, overflow, resync_err, word_count} !==
        {m_done, m_done && !m_ovf, m_ovf, m_resync, 5'(m_count)}) begin
      n_fail++;
      $display("FAIL dterm_state: got %b%b%b%b/%0d expected %b%b%b%b/%0d",
               write_done, core_resetn, overflow, resync_err, word_count,
               m_done, m_done && !m_ovf, m_ovf, m_resync, m_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 5; i++) send_word(rand_word(), 0);
    w = rand_word();
    for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8], 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = w[31:24];
    model_byte(w[31:24]);
    cyc(1);
    bus.rx_valid = 1'b0;
    n_checks++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, exp_q[$]}) begin
      n_fail++;
      $display("FAIL b2b_strobe: got %b/%h/%h expected 1/%h",
               bus.imem_we, bus.imem_addr, bus.imem_wdata, exp_q[$]);
    end
    n_checks++;
    if (word_count !== 5'(m_count)) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected %0d", word_count, m_count);
    end
    cyc(1);
    n_checks++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b0, exp_q[$]}) begin
      n_fail++;
      $display("FAIL b2b_hold: got %b/%h/%h expected 0/%h",
               bus.imem_we, bus.imem_addr, bus.imem_wdata, exp_q[$]);
    end
    n_checks++;
    if (got_q != exp_q) begin
      n_fail++;
      $display("FAIL b2b_writes: got %p expected %p", got_q, exp_q);
    end
  endtask

  task automatic test_random_load();
    int n;
    do_reset();
    n = $urandom_range(1, 12);
    for (int i = 0; i < n; i++) send_word(rand_word(), $urandom_range(0, 3));
    send_word(DEF_END_WORD, $urandom_range(0, 3));
    cyc(2);
    n_checks++;
    if (got_q != exp_q) begin
      n_fail++;
      $display("FAIL rand_writes: got %p expected %p", got_q, exp_q);
    end
    n_checks++;
    if ({write_done, core_resetn, overflow, word_count} !==
        {m_done, m_done && !m_ovf, m_ovf, 5'(m_count)}) begin
      n_fail++;
      $display("FAIL rand_state: got %b%b%b/%0d expected %b%b%b/%0d",
               write_done, core_resetn, overflow, word_count,
               m_done, m_done && !m_ovf, m_ovf, m_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++)
      send_word(rand_word(), $urandom_range(0, 2));
    send_word(rand_word(), 0);
    cyc(2);
    n_checks++;
    if (got_q.size() != DEPTH || got_q != exp_q) begin
      n_fail++;
      $display("FAIL ovf_writes: got %0d writes expected %0d",
               got_q.size(), exp_q.size());
    end
    n_checks++;
    if ({overflow, write_done, core_resetn} !== 3'b110 ||
        {m_ovf, m_done} != 2'b11) begin
      n_fail++;
      $display("FAIL ovf_flags: got %b%b%b expected 110",
               overflow, write_done, core_resetn);
    end
    n_checks++;
    if (word_count !== 5'(DEPTH)) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d expected %0d", word_count, DEPTH);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'h13, 0);
    send_byte(8'h01, 0);
    cyc(TO - 1);
    n_checks++;
    if (resync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_early: got %b expected 0", resync_err);
    end
    cyc(1);
    model_drop();
    n_checks++;
    if (resync_err !== 1'b1 || !m_resync) begin
      n_fail++;
      $display("FAIL tmo_fire: got %b expected 1", resync_err);
    end
    send_word(32'h0010_0793, 0);
    send_word(rand_word(), TO - 1);
    cyc(2);
    n_checks++;
    if (got_q.size() == 0 || got_q[0] !== {4'd0, 32'h0010_0793}) begin
      n_fail++;
      $display("FAIL tmo_first: got %p expected 0/00100793", got_q);
    end
    n_checks++;
    if (got_q != exp_q || word_count !== 5'd2) begin
      n_fail++;
      $display("FAIL tmo_slow_word: got %p/%0d expected %p/2",
               got_q, word_count, exp_q);
    end
  endtask

  task automatic test_break();
    do_reset();
    send_word(rand_word(), 1);
    bus.rx_break = 1'b1;
    model_drop();
    cyc(1);
    bus.rx_break = 1'b0;
    cyc(1);
    n_checks++;
    if (resync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL brk_idle: got %b expected 0", resync_err);
    end
    send_byte($urandom, 0);
    send_byte($urandom, 1);
    bus.rx_break = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = $urandom;
    model_drop();
    cyc(1);
    bus.rx_break = 1'b0;
    bus.rx_valid = 1'b0;
    cyc(1);
    n_checks++;
    if (resync_err !== 1'b1 || !m_resync) begin
      n_fail++;
      $display("FAIL brk_drop: got %b expected 1", resync_err);
    end
    send_word(rand_word(), 0);
    cyc(2);
    n_checks++;
    if (got_q != exp_q || word_count !== 5'd2) begin
      n_fail++;
      $display("FAIL brk_writes: got %p/%0d expected %p/2",
               got_q, word_count, exp_q);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(rand_word(), 0);
    send_word(rand_word(), 1);
    send_byte($urandom, 0);
    send_byte($urandom, 0);
    do_reset();
    n_checks++;
    if ({word_count, write_done, core_resetn, overflow, resync_err,
         bus.imem_we, bus.imem_addr, bus.imem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL rmid_clear: got %0d/%b%b%b%b/%b/%h/%h expected all 0",
               word_count, write_done, core_resetn, overflow, resync_err,
               bus.imem_we, bus.imem_addr, bus.imem_wdata);
    end
    for (int i = 0; i < 3; i++) send_word(rand_word(), $urandom_range(0, 2));
    send_word(DEF_END_WORD, 0);
    cyc(2);
    n_checks++;
    if (got_q != exp_q || got_q.size() != 3 || got_q[0][AW+31:32] !== '0) begin
      n_fail++;
      $display("FAIL rmid_writes: got %p expected %p", got_q, exp_q);
    end
    n_checks++;
    if ({write_done, core_resetn, word_count} !== {2'b11, 5'd3}) begin
      n_fail++;
      $display("FAIL rmid_done: got %b%b/%0d expected 11/3",
               write_done, core_resetn, word_count);
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_break = 1'b0;
    bus.rx_data  = '0;
    test_reset();
    test_basic();
    test_double_term();
    test_back_to_back();
    for (int k = 0; k < 3; k++) test_random_load();
    test_overflow();
    test_timeout();
    test_break();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
